// File: rtl/idct_pkg.sv
// idct_pkg: shared FSM state type, transform size and 12-bit-scaled 8-point DCT basis T[k][n]
package idct_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_e;
   localparam int N = 8;
   localparam int T [N][N] = '{
      '{1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448},
      '{2008,  1702,  1137,   399,  -399, -1137, -1702, -2008},
      '{1892,   783,  -783, -1892, -1892,  -783,   783,  1892},
      '{1702,  -399, -2008, -1137,  1137,  2008,   399, -1702},
      '{1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448},
      '{1137, -2008,   399,  1702, -1702,  -399,  2008, -1137},
      '{ 783, -1892,  1892,  -783,  -783,  1892, -1892,   783},
      '{ 399, -1137,  1702, -2008,  2008, -1702,  1137,  -399}
   };
endpackage

// File: rtl/idct_coef_rom.sv
// idct_coef_rom: combinational coefficient lookup for one MAC lane
//   mode_i  : 0 = inverse (coef T[step][idx]), 1 = forward (coef T[idx][step])
//   idx_i   : output index the lane is producing
//   step_i  : sample index being accumulated this cycle
//   coef_o  : signed 13-bit coefficient
module idct_coef_rom import idct_pkg::*; (
   input  logic              mode_i,
   input  logic [2:0]        idx_i,
   input  logic [2:0]        step_i,
   output logic signed [12:0] coef_o
);
   assign coef_o = 13'(mode_i ? T[idx_i][step_i] : T[step_i][idx_i]);
endmodule

// File: rtl/idct_mac_engine.sv
// idct_mac_engine: 8-point DCT/IDCT using NUM_MAC parallel multiply-accumulate lanes
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   start_i, mode_i          : begin a transform (IDLE only); 0 = inverse, 1 = forward
//   in_valid_i/in_ready_o    : sample handshake, in_data_i signed DATA_W sample
//   out_valid_o/out_ready_i  : result handshake, out_data_o signed OUT_W, out_index_o 0..7
//   busy_o                   : high whenever not IDLE
module idct_mac_engine import idct_pkg::*; #(
   parameter int DATA_W  = 16,
   parameter int OUT_W   = 16,
   parameter int SHIFT   = 8,
   parameter int NUM_MAC = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              mode_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [OUT_W-1:0]  out_data_o,
   output logic [2:0]        out_index_o,
   output logic              busy_o
);
   localparam int ACC_W = DATA_W + 16;
   localparam int PASSES = N / NUM_MAC;
   localparam logic signed [ACC_W-1:0] ZERO = '0;
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(2 ** (SHIFT - 1));
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
   if (NUM_MAC != 1 && NUM_MAC != 2 && NUM_MAC != 4 && NUM_MAC != 8) begin : g_bad_num_mac
      $error("idct_mac_engine: NUM_MAC must be 1, 2, 4 or 8");
   end
   state_e state_q, state_d;
   logic mode_q, mode_d;
   logic [2:0] cnt_q, cnt_d, pass_q, pass_d;
   logic signed [DATA_W-1:0] x_q [N], x_d [N];
   logic signed [ACC_W-1:0] acc_q [NUM_MAC], acc_d [NUM_MAC], sum_w [NUM_MAC], rnd_w [NUM_MAC];
   logic signed [OUT_W-1:0] res_q [N], res_d [N], sat_w [NUM_MAC];
   logic signed [12:0] coef_w [NUM_MAC];
   for (genvar l = 0; l < NUM_MAC; l++) begin : g_lane
      idct_coef_rom u_rom (
         .mode_i (mode_q),
         .idx_i  (3'(pass_q * NUM_MAC + l)),
         .step_i (cnt_q),
         .coef_o (coef_w[l])
      );
      // step 0 restarts the accumulation, so no separate clear cycle is needed between passes
      assign sum_w[l] = (cnt_q == 3'd0 ? ZERO : acc_q[l]) + ACC_W'(coef_w[l]) * ACC_W'(x_q[cnt_q]);
      assign rnd_w[l] = (sum_w[l] + RND) >>> SHIFT;
      assign sat_w[l] = rnd_w[l] > MAXV ? OUT_W'(MAXV) : (rnd_w[l] < MINV ? OUT_W'(MINV) : OUT_W'(rnd_w[l]));
   end
   always_comb begin
      state_d = state_q;
      mode_d = mode_q;
      cnt_d = cnt_q;
      pass_d = pass_q;
      x_d = x_q;
      acc_d = acc_q;
      res_d = res_q;
      case (state_q)
         IDLE: if (start_i) begin
            state_d = LOAD;
            mode_d = mode_i;
            cnt_d = '0;
         end
         LOAD: if (in_valid_i) begin
            x_d[cnt_q] = $signed(in_data_i);
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = COMPUTE;
               pass_d = '0;
            end
         end
         COMPUTE: begin
            cnt_d = cnt_q + 3'd1;
            acc_d = sum_w;
            if (cnt_q == 3'd7) begin
               for (int l = 0; l < NUM_MAC; l++) res_d[3'(pass_q * NUM_MAC + l)] = sat_w[l];
               pass_d = pass_q + 3'd1;
               if (pass_q == 3'(PASSES - 1)) state_d = OUTPUT;
            end
         end
         OUTPUT: if (out_ready_i) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         mode_q <= 1'b0;
         cnt_q <= '0;
         pass_q <= '0;
         x_q <= '{default: '0};
         acc_q <= '{default: '0};
         res_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         mode_q <= mode_d;
         cnt_q <= cnt_d;
         pass_q <= pass_d;
         x_q <= x_d;
         acc_q <= acc_d;
         res_q <= res_d;
      end
   end
   assign in_ready_o = state_q == LOAD;
   assign out_valid_o = state_q == OUTPUT;
   assign busy_o = state_q != IDLE;
   assign out_data_o = out_valid_o ? res_q[cnt_q] : '0;
   assign out_index_o = out_valid_o ? cnt_q : '0;
endmodule
